// File: rtl/router_pkg.sv
// Shared router constants and the destination-receiver FSM state type.
package router_pkg;

  localparam int DATA_W   = 8;
  localparam int LEN_W    = 6;
  localparam int ADDR_W   = 2;
  localparam int MAX_WAIT = 29;
  localparam int WAIT_W   = 5;
  // Wide enough for the largest packet: 63 payload bytes + header + parity.
  localparam int CNT_W    = 7;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_WAIT = 2'd1,
    RX_READ = 2'd2,
    RX_DONE = 2'd3
  } rx_state_t;

  function automatic logic [WAIT_W-1:0] clamp_wait(input logic [WAIT_W-1:0] dly);
    return (dly > WAIT_W'(MAX_WAIT)) ? WAIT_W'(MAX_WAIT) : dly;
  endfunction

endpackage

// File: rtl/router_rx_parity.sv
// Running XOR accumulator over received packet bytes.
// Only present when ROUTER_RX_PARITY_CHK_EN is defined.
`ifdef ROUTER_RX_PARITY_CHK_EN
module router_rx_parity
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] parity
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      parity <= '0;
    end else if (enable) begin
      parity <= parity ^ data_in;
    end
  end

endmodule
`endif

// File: rtl/router_dest_rx.sv
// Router output-port receiver: waits start_dly, drains one packet from the FIFO, splits header/payload/parity.
// Parity checking is compiled in only when ROUTER_RX_PARITY_CHK_EN is defined.
module router_dest_rx
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              vld_out,
  input  logic [DATA_W-1:0] data_out,
  input  logic              soft_reset,
  input  logic [4:0]        start_dly,
  output logic              read_enb,
  output logic [DATA_W-1:0] pyld_data,
  output logic              pyld_vld,
  output logic [ADDR_W-1:0] pkt_addr,
  output logic [LEN_W-1:0]  pkt_len,
  output logic              pkt_done,
  output logic              parity_err,
  output logic              pkt_abort,
  output logic [1:0]        state_dbg
);

  // Handshake: read_enb is only raised while vld_out=1; the FIFO presents the
  // read byte on data_out in the following cycle, which is the capture cycle.

  rx_state_t         state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  rd_cnt_q, cap_cnt_q, total_q;
  logic              hdr_seen_q, cap_pend_q;
  logic              capture, is_hdr, is_parity, is_pyld, aborting;

  assign capture   = (state_q == RX_READ) && cap_pend_q && !soft_reset;
  assign is_hdr    = (cap_cnt_q == '0);
  assign is_parity = hdr_seen_q && (cap_cnt_q == total_q - 7'd1);
  assign is_pyld   = !is_hdr && !is_parity;

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    read_enb = 1'b0;
    aborting = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (vld_out) begin
          state_d = RX_WAIT;
          wait_d  = clamp_wait(start_dly);
        end
      end
      RX_WAIT: begin
        if (soft_reset) begin
          state_d  = RX_IDLE;
          aborting = 1'b1;
        end else if (wait_q == '0) begin
          state_d = RX_READ;
        end else begin
          wait_d = wait_q - 5'd1;
        end
      end
      RX_READ: begin
        if (soft_reset) begin
          state_d  = RX_IDLE;
          aborting = 1'b1;
        end else begin
          // Until the header is seen the packet length is unknown, so keep reading.
          read_enb = vld_out && (!hdr_seen_q || (rd_cnt_q < total_q));
          if (capture && is_parity) state_d = RX_DONE;
        end
      end
      RX_DONE: begin
        if (vld_out) begin
          state_d = RX_WAIT;
          wait_d  = clamp_wait(start_dly);
        end else begin
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RX_IDLE;
      wait_q     <= '0;
      rd_cnt_q   <= '0;
      cap_cnt_q  <= '0;
      total_q    <= '0;
      hdr_seen_q <= 1'b0;
      cap_pend_q <= 1'b0;
      pkt_abort  <= 1'b0;
      pyld_vld   <= 1'b0;
      pyld_data  <= '0;
      pkt_addr   <= '0;
      pkt_len    <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      cap_pend_q <= read_enb;
      pkt_abort  <= aborting;
      pyld_vld   <= capture && is_pyld;
      if (capture && is_pyld) pyld_data <= data_out;
      if (state_q != RX_READ) begin
        rd_cnt_q   <= '0;
        cap_cnt_q  <= '0;
        total_q    <= '0;
        hdr_seen_q <= 1'b0;
      end else begin
        if (read_enb) rd_cnt_q <= rd_cnt_q + 7'd1;
        if (capture) begin
          cap_cnt_q <= cap_cnt_q + 7'd1;
          if (is_hdr) begin
            hdr_seen_q <= 1'b1;
            total_q    <= {1'b0, data_out[7:2]} + 7'd2;
            pkt_addr   <= data_out[1:0];
            pkt_len    <= data_out[7:2];
          end
        end
      end
    end
  end

  assign pkt_done  = (state_q == RX_DONE);
  assign state_dbg = state_q;

`ifdef ROUTER_RX_PARITY_CHK_EN
  logic [DATA_W-1:0] par_acc;
  logic              par_bad_q;

  router_rx_parity u_parity (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q != RX_READ),
    .enable  (capture && !is_parity),
    .data_in (data_out),
    .parity  (par_acc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      par_bad_q <= 1'b0;
    end else if (capture && is_parity) begin
      par_bad_q <= (par_acc != data_out);
    end
  end

  assign parity_err = pkt_done && par_bad_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_dest_rx.sv
// Directed + randomized bench for router_dest_rx with a queue-based FIFO and packet model.
module tb_router_dest_rx;

  logic       clk = 1'b0;
  logic       reset, vld_out, soft_reset;
  logic [7:0] data_out;
  logic [4:0] start_dly;
  logic       read_enb, pyld_vld, pkt_done, parity_err, pkt_abort;
  logic [7:0] pyld_data;
  logic [1:0] pkt_addr, state_dbg;
  logic [5:0] pkt_len;

  router_dest_rx dut (
    .clk(clk), .reset(reset), .vld_out(vld_out), .data_out(data_out),
    .soft_reset(soft_reset), .start_dly(start_dly), .read_enb(read_enb),
    .pyld_data(pyld_data), .pyld_vld(pyld_vld), .pkt_addr(pkt_addr),
    .pkt_len(pkt_len), .pkt_done(pkt_done), .parity_err(parity_err),
    .pkt_abort(pkt_abort), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo[$];
  logic [7:0] pay_q[$];
  logic [7:0] got_q[$];
  logic [7:0] pend;
  bit         have_pend;
  int n_rd, n_done, n_stray, n_abort, cyc, first_rd, last_rd, done_cyc;
  logic last_perr;
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, observe 1 time unit later.
  task automatic tick(input bit en, input bit sr);
    @(negedge clk);
    data_out   = have_pend ? pend : 8'($urandom);
    have_pend  = 1'b0;
    vld_out    = en && (fifo.size() != 0);
    soft_reset = sr;
    #1;
    if (read_enb) begin
      if (fifo.size() != 0) begin
        pend      = fifo.pop_front();
        have_pend = 1'b1;
      end
      n_rd++;
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
    end
    if (pyld_vld) got_q.push_back(pyld_data);
    if (pkt_done) begin
      n_done++;
      last_perr = parity_err;
      done_cyc  = cyc;
    end
    if (parity_err && !pkt_done) n_stray++;
    if (pkt_abort) n_abort++;
    cyc++;
  endtask

  task automatic clear_obs();
    n_rd = 0; n_done = 0; n_stray = 0; n_abort = 0; cyc = 0;
    first_rd = -1; last_rd = -1; done_cyc = -1; last_perr = 1'b0;
    got_q.delete();
  endtask

  task automatic load_fifo(input logic [7:0] hdr, input logic [7:0] par);
    fifo.delete();
    have_pend = 1'b0;
    fifo.push_back(hdr);
    foreach (pay_q[i]) fifo.push_back(pay_q[i]);
    fifo.push_back(par);
  endtask

  // Sends hdr + pay_q + par and checks everything the packet should produce.
  task automatic run_packet(input string tag, input logic [7:0] hdr, input logic [7:0] par,
                            input int sd, input int stall_after, input int stall_len);
    logic [7:0] x;
    logic       exp_perr;
    int len, wait_cyc, stalled, n_stall_rd, n_bad;
    bit en;
    len = int'(hdr[7:2]);
    x = hdr;
    foreach (pay_q[i]) x = x ^ pay_q[i];
`ifdef ROUTER_RX_PARITY_CHK_EN
    exp_perr = (par != x);
`else
    exp_perr = 1'b0;
`endif
    wait_cyc = (sd > 29) ? 30 : sd + 1;
    start_dly = 5'(sd);
    load_fifo(hdr, par);
    clear_obs();
    stalled = 0;
    n_stall_rd = 0;
    for (int c = 0; c < 500 && n_done == 0; c++) begin
      en = 1'b1;
      if (stall_after >= 0 && n_rd == stall_after && stalled < stall_len) begin
        en = 1'b0;
        stalled++;
      end
      tick(en, 1'b0);
      if (!en && read_enb) n_stall_rd++;
    end
    check({tag, "_done"}, n_done, 1);
    check({tag, "_reads"}, n_rd, len + 2);
    check({tag, "_first_rd"}, first_rd, wait_cyc + 1);
    check({tag, "_rd_span"}, last_rd - first_rd, len + 1 + stalled);
    check({tag, "_done_lat"}, done_cyc - last_rd, 2);
    check({tag, "_pyld_cnt"}, got_q.size(), len);
    n_bad = 0;
    foreach (pay_q[i]) if (i >= got_q.size() || got_q[i] !== pay_q[i]) n_bad++;
    check({tag, "_pyld_data"}, n_bad, 0);
    check({tag, "_addr"}, pkt_addr, hdr[1:0]);
    check({tag, "_len"}, pkt_len, hdr[7:2]);
    check({tag, "_perr"}, last_perr, exp_perr);
    check({tag, "_perr_stray"}, n_stray, 0);
    check({tag, "_abort"}, n_abort, 0);
    if (stalled > 0) check({tag, "_stall_rd"}, n_stall_rd, 0);
    tick(1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_read_enb"}, read_enb, 0);
    check({tag, "_pyld_vld"}, pyld_vld, 0);
    check({tag, "_pyld_data"}, pyld_data, 0);
    check({tag, "_pkt_addr"}, pkt_addr, 0);
    check({tag, "_pkt_len"}, pkt_len, 0);
    check({tag, "_pkt_done"}, pkt_done, 0);
    check({tag, "_parity_err"}, parity_err, 0);
    check({tag, "_pkt_abort"}, pkt_abort, 0);
  endtask

  task automatic read_until(input int n);
    for (int c = 0; c < 200 && n_rd < n; c++) tick(1'b1, 1'b0);
    check("reach_read_count", n_rd, n);
  endtask

  initial begin
    logic [7:0] hdr, par, x;
    int len, sd, sa, sl;

    reset = 1'b1; vld_out = 1'b0; soft_reset = 1'b0; data_out = 8'h00; start_dly = 5'd0;
    have_pend = 1'b0;
    clear_obs();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check_all_zero("por");
    reset = 1'b0;
    tick(1'b0, 1'b0);

    // Basic packet, good parity.
    pay_q = '{8'h11, 8'h22, 8'h33};
    run_packet("basic", 8'h0D, 8'h0D ^ 8'h11 ^ 8'h22 ^ 8'h33, 3, -1, 0);

    // Same packet with a corrupted parity byte.
    run_packet("badpar", 8'h0D, 8'hFF, 3, -1, 0);

    // vld_out drops for two cycles after the second payload read.
    run_packet("stall", 8'h0D, 8'h0D ^ 8'h11 ^ 8'h22 ^ 8'h33, 3, 3, 2);

    // start_dly above the clamp.
    pay_q = '{8'hA5};
    run_packet("clamp", 8'h06, 8'h06 ^ 8'hA5, 31, -1, 0);

    // start_dly = 0 and an empty payload.
    pay_q.delete();
    run_packet("zero", 8'h02, 8'h02, 0, -1, 0);

    // soft_reset is ignored while idle.
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    check("sr_idle_abort", pkt_abort, 0);

    // soft_reset in READ after the header has been captured.
    pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    start_dly = 5'd2;
    load_fifo(8'h12, 8'h00);
    clear_obs();
    read_until(2);
    tick(1'b1, 1'b1);
    check("sr_read_enb", read_enb, 0);
    fifo.delete();
    have_pend = 1'b0;
    tick(1'b0, 1'b0);
    check("sr_abort_pulse", pkt_abort, 1);
    tick(1'b0, 1'b0);
    check("sr_abort_single", pkt_abort, 0);
    check("sr_abort_count", n_abort, 1);
    check("sr_no_done", n_done, 0);
    pay_q = '{8'h5A, 8'hC3};
    run_packet("after_sr", 8'h0B, 8'h0B ^ 8'h5A ^ 8'hC3, 1, -1, 0);

    // Hard reset in the middle of READ.
    pay_q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70};
    start_dly = 5'd1;
    load_fifo(8'h1F, 8'h77);
    clear_obs();
    read_until(4);
    reset = 1'b1;
    tick(1'b0, 1'b1);
    check_all_zero("mid_reset");
    reset = 1'b0;
    fifo.delete();
    have_pend = 1'b0;
    tick(1'b0, 1'b0);
    pay_q.delete();
    run_packet("after_rst", 8'h00, 8'h00, 2, -1, 0);

    // Randomized packets: length, payload, parity, start delay and stall placement.
    for (int p = 0; p < 12; p++) begin
      len = int'($urandom_range(0, 12));
      hdr = {6'(len), 2'($urandom_range(0, 3))};
      pay_q.delete();
      x = hdr;
      for (int i = 0; i < len; i++) begin
        pay_q.push_back(8'($urandom));
        x = x ^ pay_q[i];
      end
      par = ($urandom_range(0, 1) == 1) ? x : (x ^ 8'($urandom_range(1, 255)));
      sd = int'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) begin
        sa = int'($urandom_range(1, len + 1));
        sl = int'($urandom_range(1, 3));
      end else begin
        sa = -1;
        sl = 0;
      end
      run_packet($sformatf("rnd%0d", p), hdr, par, sd, sa, sl);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/router_dest_rx.md
ROUTER_DEST_RX -- requirements
Module: router_dest_rx

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port vld_out  input  1  output-port FIFO non-empty, from router_sync.
REQ-004 SHALL have port data_out  input  8  FIFO read data, valid the cycle after a read_enb cycle.
REQ-005 SHALL have port soft_reset  input  1  port timeout flush, from router_sync.
REQ-006 SHALL have port start_dly  input  5  cycles to wait after vld_out before first read.
REQ-007 SHALL have port read_enb  output  1  FIFO read strobe.
REQ-008 SHALL have port pyld_data  output  8  captured payload byte.
REQ-009 SHALL have port pyld_vld  output  1  pyld_data valid, one cycle per payload byte.
REQ-010 SHALL have port pkt_addr  output  2  header[1:0] of the current/last packet.
REQ-011 SHALL have port pkt_len  output  6  header[7:2] of the current/last packet.
REQ-012 SHALL have port pkt_done  output  1  one-cycle pulse on packet completion.
REQ-013 SHALL have port parity_err  output  1  one-cycle pulse with pkt_done on parity mismatch.
REQ-014 SHALL have port pkt_abort  output  1  one-cycle pulse when soft_reset kills an in-flight packet.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, READ, DONE.
REQ-016 IDLE -> WAIT when vld_out=1; WAIT counter loads min(start_dly,29).
REQ-017 WAIT SHALL decrement each cycle; -> READ the cycle the counter equals 0 (start_dly=0 gives one WAIT cycle).
REQ-018 READ: read_enb = vld_out AND (reads_issued < total); total unknown until header captured, treated as infinite before then.
REQ-019 Packet = header, pkt_len payload bytes, parity byte; total reads = pkt_len+2; pkt_len=0 legal (2 reads).
REQ-020 Capture SHALL occur in the cycle after each read_enb=1 cycle; capture 1 = header, last capture = parity, others = payload (pyld_vld=1).
REQ-021 vld_out=0 mid-packet SHALL stall: read_enb=0, no capture next cycle, counters hold, no error.
REQ-022 READ -> DONE the cycle after the parity capture; DONE drives pkt_done=1 for one cycle then -> IDLE (or WAIT if vld_out=1).
REQ-023 Parity SHALL be XOR of header and all payload bytes compared with parity byte; mismatch -> parity_err=1 in DONE cycle.
REQ-024 soft_reset=1 in WAIT or READ SHALL force IDLE next cycle, read_enb=0 same cycle, pkt_abort=1 for one cycle, no pkt_done; ignored in IDLE/DONE.
REQ-025 pkt_addr/pkt_len SHALL update at header capture and hold until next header.

Reset
REQ-026 reset=1 SHALL force IDLE and all outputs and counters to 0 at next edge, overriding soft_reset and any in-flight packet.

Configuration
REQ-027 Macro ROUTER_RX_PARITY_CHK_EN defined: parity accumulation and parity_err per REQ-023.
REQ-028 Macro undefined: no parity logic, parity_err tied 0; parity byte still read and discarded; timing unchanged.

Structure
REQ-029 Shared package router_pkg SHALL hold DATA_W=8, LEN_W=6, ADDR_W=2, MAX_WAIT=29 and the rx FSM state typedef.
REQ-030 Parity accumulator SHALL be sub-module router_rx_parity (clear, enable, byte in, running XOR out), instantiated only under ROUTER_RX_PARITY_CHK_EN.

Verification
REQ-031 start_dly=3, vld_out=1, header 8'h0D (len 3, addr 1), payload 11/22/33, parity 8'h0D^11^22^33 -> read_enb high 5 consecutive cycles after 4 WAIT cycles; pyld_vld 3 cycles; pkt_done=1, parity_err=0.
REQ-032 Same packet, parity byte 8'hFF -> pkt_done=1 and parity_err=1 same cycle (0 with macro undefined).
REQ-033 vld_out dropped 2 cycles after second payload read -> read_enb 0 for those cycles, no pyld_vld gap error, packet completes intact.
REQ-034 start_dly=31 -> WAIT lasts 30 cycles (clamped), first read_enb before router_sync 30-cycle timeout.
REQ-035 soft_reset during READ after header -> read_enb 0 same cycle, pkt_abort pulse, IDLE, no pkt_done; next packet received correctly.
REQ-036 reset asserted mid-READ -> all outputs 0 next cycle; header 8'h00 packet afterwards -> 2 reads, pkt_done=1.
